// File: rtl/souper_pkg.sv
// Shared types and defaults for the expansion-audio command queue.
// Holds the handshake FSM state encoding and the default queue sizing.
package souper_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    WAIT  = 2'd2
  } aud_state_e;

  localparam int DEF_DEPTH   = 4;
  localparam int DEF_TIMEOUT = 4096;

endpackage

// File: rtl/souper_cmd_fifo.sv
// Command byte FIFO for the audio queue.
// Power-of-two depth; a pop frees room for a push in the same cycle.
module souper_cmd_fifo
  import souper_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               push_data,
  output logic [7:0]               head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk_sys) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/souper_aud_queue.sv
// Queues 6502 writes to $8007 and hands them to the expansion
// processor over a toggle req/ack handshake with timeout.
module souper_aud_queue
  import souper_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   wr_stb,
  input  logic [7:0]             wr_data,
  input  logic                   aud_ack,
  input  logic                   clr_flags,
  output logic [7:0]             aud_com,
  output logic                   aud_req,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy,
  output logic                   ovf,
  output logic                   tmo
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] FULL  = CW'(DEPTH);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  aud_state_e    state;
  logic          ack_m;
  logic          ack_s;
  logic [TW-1:0] tcnt;
  logic [7:0]    head;
  logic          push;
  logic          pop;
  logic          full;

  assign full = (count == FULL);
  assign pop  = (state == IDLE) && (count != '0);
  assign push = wr_stb && !reset;

  souper_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (wr_data),
    .head      (head),
    .count     (count)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ack_m <= 1'b0;
      ack_s <= 1'b0;
    end else begin
      ack_m <= aud_ack;
      ack_s <= ack_m;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (wr_stb && full && !pop) begin
      ovf <= 1'b1;
    end else if (clr_flags) begin
      ovf <= 1'b0;
    end
  end

  // Later tmo assignment in WAIT overrides the clear, so a set wins.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      aud_com <= 8'h00;
      aud_req <= 1'b0;
      busy    <= 1'b0;
      tcnt    <= '0;
      tmo     <= 1'b0;
    end else begin
      if (clr_flags) begin
        tmo <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (pop) begin
            aud_com <= head;
            state   <= SETUP;
            busy    <= 1'b1;
          end
        end
        SETUP: begin
          aud_req <= ~ack_s;
          tcnt    <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          if (ack_s == aud_req) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (tcnt == TLAST) begin
            tmo   <= 1'b1;
            state <= IDLE;
            busy  <= 1'b0;
          end else if (tcnt != '1) begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_souper_aud_queue.sv
// Directed bench for souper_aud_queue with a launch-order scoreboard.
module tb_souper_aud_queue;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic       wr_stb;
  logic [7:0] wr_data;
  logic       aud_ack;
  logic       clr_flags;
  logic [7:0] aud_com;
  logic       aud_req;
  logic [2:0] count;
  logic       busy;
  logic       ovf;
  logic       tmo;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q [$];
  logic       prev_busy = 1'b0;

  always #5 clk_sys = ~clk_sys;

  souper_aud_queue #(
    .DEPTH   (4),
    .TIMEOUT (16)
  ) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .wr_stb    (wr_stb),
    .wr_data   (wr_data),
    .aud_ack   (aud_ack),
    .clr_flags (clr_flags),
    .aud_com   (aud_com),
    .aud_req   (aud_req),
    .count     (count),
    .busy      (busy),
    .ovf       (ovf),
    .tmo       (tmo)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Each launch (busy rising) must present the next expected byte.
  always @(negedge clk_sys) begin
    logic [7:0] e;
    if (busy && !prev_busy) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL launch_unexpected observed=%0h expected=none", aud_com);
      end else begin
        e = exp_q.pop_front();
        check("launch_byte", {24'd0, aud_com}, {24'd0, e});
      end
    end
    prev_busy <= busy;
  end

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    wr_stb    = 1'b0;
    clr_flags = 1'b0;
    exp_q.delete();
    step();
    step();
    reset = 1'b0;
    step();
    step();
    step();
  endtask

  task automatic wr(input logic [7:0] d, input bit accept);
    wr_stb  = 1'b1;
    wr_data = d;
    if (accept) exp_q.push_back(d);
    step();
    wr_stb = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400; i++) begin
      if (count == 0 && !busy) break;
      step();
    end
    check({tag, "_idle"}, {31'd0, (count == 0 && !busy)}, 32'd1);
    check({tag, "_sb_empty"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    wr_stb    = 1'b0;
    wr_data   = 8'h00;
    aud_ack   = 1'b0;
    clr_flags = 1'b0;

    // Reset values; a strobe during reset is ignored.
    step();
    wr_stb  = 1'b1;
    wr_data = 8'h77;
    step();
    step();
    check("rst_count", count, 0);
    check("rst_aud_com", aud_com, 8'h00);
    check("rst_aud_req", aud_req, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    check("rst_tmo", tmo, 0);
    wr_stb = 1'b0;
    reset  = 1'b0;
    step();
    step();
    step();
    check("rst_wr_ignored", count, 0);

    // Single command, basic handshake timing.
    wr(8'hA5, 1);
    check("a5_count", count, 1);
    step();
    check("a5_aud_com", aud_com, 8'hA5);
    check("a5_busy", busy, 1);
    step();
    check("a5_aud_req", aud_req, 1);
    aud_ack = 1'b1;
    step();
    step();
    check("a5_busy_hold", busy, 1);
    step();
    check("a5_busy_fall", busy, 0);

    // Timeout, next launch, clear and set-wins.
    aud_ack = 1'b0;
    do_reset();
    wr(8'h11, 1);
    wr(8'h22, 1);
    check("to_aud_com", aud_com, 8'h11);
    step();
    check("to_aud_req", aud_req, 1);
    repeat (15) step();
    check("to_tmo_early", tmo, 0);
    step();
    check("to_tmo_set", tmo, 1);
    check("to_busy_idle", busy, 0);
    step();
    check("to_next_com", aud_com, 8'h22);
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    check("to_tmo_clr", tmo, 0);
    repeat (15) step();
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    check("to_set_wins", tmo, 1);
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    check("to_tmo_clr2", tmo, 0);

    // Overflow with a full FIFO.
    do_reset();
    for (int i = 1; i <= 5; i++) wr(8'(i), 1);
    check("ov_count4", count, 4);
    check("ov_no_ovf", ovf, 0);
    wr(8'h06, 0);
    check("ov_count_hold", count, 4);
    check("ov_ovf", ovf, 1);
    check("ov_first_com", aud_com, 8'h01);
    drain("ov_drain");
    check("ov_tmo", tmo, 1);
    check("ov_ovf_sticky", ovf, 1);
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    check("ov_ovf_clr", ovf, 0);
    check("ov_tmo_clr", tmo, 0);

    // Reset in WAIT with queued entries.
    aud_ack = 1'b0;
    do_reset();
    wr(8'hA1, 1);
    wr(8'hA2, 1);
    wr(8'hA3, 1);
    wr(8'hA4, 1);
    check("mr_count3", count, 3);
    check("mr_req", aud_req, 1);
    reset = 1'b1;
    #1;
    check("mr_count0", count, 0);
    check("mr_req0", aud_req, 0);
    check("mr_busy0", busy, 0);
    exp_q.delete();
    aud_ack = 1'b1;
    step();
    reset = 1'b0;
    step();
    step();
    step();
    wr(8'h5A, 1);
    step();
    step();
    check("mr_setup_req", aud_req, 0);
    check("mr_busy", busy, 1);
    aud_ack = 1'b0;
    step();
    step();
    check("mr_busy_hold", busy, 1);
    step();
    check("mr_done", busy, 0);

    // Write on the same edge as an IDLE pop with FIFO full.
    aud_ack = 1'b0;
    do_reset();
    for (int i = 1; i <= 5; i++) wr(8'(i), 1);
    aud_ack = 1'b1;
    step();
    step();
    step();
    check("fp_idle", busy, 0);
    check("fp_full", count, 4);
    wr(8'h06, 1);
    check("fp_count", count, 4);
    check("fp_ovf", ovf, 0);
    check("fp_com", aud_com, 8'h02);
    drain("fp_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/souper_aud_queue.md
SOUPER_AUD_QUEUE -- requirements
Module: souper_aud_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4: command FIFO entries, power of two, minimum 2.
REQ-002 The block SHALL have parameter TIMEOUT, default 4096: maximum clk_sys cycles to wait for an acknowledge.
REQ-003 The block SHALL have port clk_sys, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port wr_stb, input, 1 bit: one-cycle strobe for a 6502 write to mapper register $7 ($8007).
REQ-006 The block SHALL have port wr_data, input, 8 bits: command byte qualified by wr_stb.
REQ-007 The block SHALL have port aud_ack, input, 1 bit: acknowledge toggle from the expansion processor, asynchronous to clk_sys.
REQ-008 The block SHALL have port clr_flags, input, 1 bit: one-cycle strobe that clears ovf and tmo.
REQ-009 The block SHALL have port aud_com, output, 8 bits: command byte presented to the expansion processor.
REQ-010 The block SHALL have port aud_req, output, 1 bit: request toggle level.
REQ-011 The block SHALL have port count, output, clog2(DEPTH)+1 bits: FIFO occupancy.
REQ-012 The block SHALL have port busy, output, 1 bit: high when the state is not IDLE.
REQ-013 The block SHALL have port ovf, output, 1 bit: sticky flag, a write was dropped.
REQ-014 The block SHALL have port tmo, output, 1 bit: sticky flag, an acknowledge timed out.

Function
REQ-015 aud_ack SHALL pass through a two-flop synchronizer to give ack_s before any use.
REQ-016 On wr_stb, wr_data SHALL be pushed if count<DEPTH, or if a pop occurs in the same cycle; count updates on the next edge.
REQ-017 When wr_stb is asserted, count==DEPTH and no pop occurs in that cycle, the byte SHALL be dropped and ovf set on the next edge.
REQ-018 FIFO pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow.
REQ-019 The FSM SHALL use states IDLE, SETUP and WAIT.
REQ-020 In IDLE with count>0, the FSM SHALL load aud_com from the FIFO head, pop the entry and go to SETUP; a byte written to an empty FIFO SHALL reach aud_com 2 edges after its wr_stb edge.
REQ-021 In SETUP, the FSM SHALL drive aud_req to ~ack_s, clear the timeout counter and go to WAIT, so aud_com is stable at least one cycle before the request edge.
REQ-022 In WAIT, when ack_s==aud_req, the FSM SHALL return to IDLE; the next command may then launch on the following edge.
REQ-023 In WAIT, when the timeout counter reaches TIMEOUT-1 without an acknowledge, the FSM SHALL set tmo and go to IDLE, and the command is abandoned (not retried).
REQ-024 aud_com SHALL hold its last value outside SETUP loads.
REQ-025 An acknowledge arriving in IDLE or SETUP SHALL be ignored; SETUP re-derives aud_req from ack_s, so stale toggles never stall the block.
REQ-026 When clr_flags coincides with a new overflow or timeout event, the flag SHALL be set (set wins).
REQ-027 busy SHALL be a registered output.
REQ-028 The timeout counter SHALL be clog2(TIMEOUT) bits wide and saturating.

Reset
REQ-029 While reset is high, the FSM SHALL be in IDLE, with FIFO pointers=0, count=0, aud_com=8'h00, aud_req=0, ack_s synchronizer=0, ovf=0, tmo=0, busy=0 and timeout counter=0.
REQ-030 Reset asserted mid-WAIT SHALL abandon the command in flight and flush queued entries; the first post-reset command uses aud_req=~ack_s, whatever level the processor holds.
REQ-031 wr_stb SHALL be ignored while reset is high.

Structure
REQ-032 State encoding (IDLE/SETUP/WAIT) and default DEPTH/TIMEOUT constants SHALL live in shared package souper_pkg.
REQ-033 The FIFO storage and pointers SHALL be one sub-module, souper_cmd_fifo (push, pop, data, count); the synchronizer, FSM and flags SHALL stay in souper_aud_queue.

Verification
REQ-034 Reset, then wr_stb with 8'hA5, with aud_ack tied to 0 -> aud_com=A5 two edges later, aud_req rises one edge after that; toggling aud_ack -> busy falls 3 edges after the ack toggle (2 for the synchronizer, 1 for the FSM).
REQ-035 Five back-to-back writes 01..05 with DEPTH=4 and ack held -> the first byte launches, bytes 02..05 fill the FIFO, no ovf; a sixth write sets ovf and count stays 4.
REQ-036 No acknowledge with TIMEOUT=16 -> tmo sets 16 cycles after entering WAIT, the next byte launches, and clr_flags clears tmo.
REQ-037 Reset pulse during WAIT with 3 entries queued -> count=0, aud_req=0; with aud_ack held 1, a new write gives aud_req=0 (=~ack_s) on its SETUP edge, and the first ack toggle completes the command.
REQ-038 wr_stb on the same edge as an IDLE pop with FIFO full -> the byte is accepted, count stays DEPTH and ovf stays 0.
